// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge port between the MEM stage and memory
interface mem_stage_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWData;
  logic        dmemAck;
  logic [31:0] dmemRData;
  modport master (output dmemReq, dmemWe, dmemAddr, dmemWData, input dmemAck, dmemRData);
  modport slave  (input dmemReq, dmemWe, dmemAddr, dmemWData, output dmemAck, dmemRData);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage with branch/jump resolution and a variable-latency data-memory access FSM
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  branchType_i,
  input  logic        jump_i,
  input  logic        memToRead_i,
  input  logic        memToWrite_i,
  input  logic        memToReg_i,
  input  logic        regWrite_i,
  input  logic        zf_i,
  input  logic        sign_i,
  input  logic [31:0] branchAddr_i,
  input  logic [31:0] jumpAddr_i,
  input  logic [31:0] aluResult_i,
  input  logic [31:0] rtData_i,
  input  logic [4:0]  writeAddrReg_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic        pcSrc_o,
  output logic [31:0] pcTarget_o,
  output logic        memToReg_o,
  output logic        regWrite_o,
  output logic [31:0] readData_o,
  output logic [31:0] aluResult_o,
  output logic [4:0]  writeAddrReg_o,
  output logic        memErr_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t     state;
  logic [7:0] waitCnt;
  logic       memOp, misaligned, issue, timeout, taken, idle;
  assign idle       = state == IDLE;
  assign memOp      = memToRead_i | memToWrite_i;
  assign misaligned = memOp & (aluResult_i[1:0] != 2'b00);
  assign issue      = idle & memOp & !misaligned;
  // waitCnt holds (ACCESS cycle number - 1), so the abort lands on ACCESS cycle MAX_WAIT
  assign timeout    = !idle & !dmem.dmemAck & (waitCnt == 8'(MAX_WAIT - 1));
  assign taken      = (branchType_i == 2'b01 & zf_i) | (branchType_i == 2'b10 & !zf_i) |
                      (branchType_i == 2'b11 & sign_i);
  assign stall_o    = issue | (!idle & !dmem.dmemAck & !timeout);
  assign pcSrc_o    = idle & (jump_i | taken);
  assign pcTarget_o = !idle ? 32'd0 : jump_i ? jumpAddr_i : taken ? branchAddr_i : 32'd0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      waitCnt        <= '0;
      dmem.dmemReq   <= 1'b0;
      dmem.dmemWe    <= 1'b0;
      dmem.dmemAddr  <= '0;
      dmem.dmemWData <= '0;
      memToReg_o     <= 1'b0;
      regWrite_o     <= 1'b0;
      readData_o     <= '0;
      aluResult_o    <= '0;
      writeAddrReg_o <= '0;
      memErr_o       <= 1'b0;
    end else begin
      memErr_o <= 1'b0;
      if (issue) begin
        dmem.dmemReq   <= 1'b1;
        dmem.dmemWe    <= memToWrite_i;
        dmem.dmemAddr  <= aluResult_i;
        dmem.dmemWData <= rtData_i;
        waitCnt        <= '0;
        state          <= ACCESS;
        regWrite_o     <= 1'b0;
        memToReg_o     <= 1'b0;
      end else if (idle || dmem.dmemAck) begin
        // plain retire in IDLE (misaligned ops retire with no write-back), or access completion
        memToReg_o     <= memToReg_i;
        regWrite_o     <= regWrite_i & (idle ? !misaligned : 1'b1);
        aluResult_o    <= aluResult_i;
        writeAddrReg_o <= writeAddrReg_i;
        readData_o     <= (idle || memToWrite_i) ? 32'd0 : dmem.dmemRData;
        memErr_o       <= idle & misaligned;
        dmem.dmemReq   <= 1'b0;
        state          <= IDLE;
      end else if (timeout) begin
        dmem.dmemReq <= 1'b0;
        memErr_o     <= 1'b1;
        regWrite_o   <= 1'b0;
        memToReg_o   <= 1'b0;
        state        <= IDLE;
      end else begin
        waitCnt    <= waitCnt + 8'd1;
        regWrite_o <= 1'b0;
        memToReg_o <= 1'b0;
      end
    end
  end
endmodule
